// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack clock-domain crossing: captures a word,
// holds it stable on TX_DATA and walks REQ/ACK through a synchronized acknowledge.
module cdc_handshake_tx #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 TX_ACK,
  output logic                 DONE,
  output logic                 BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] sync_q;
  logic                  ack_s;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  // Acknowledge synchronizer; only the last stage is ever looked at.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], TX_ACK};
    end
  end

  assign ack_s    = sync_q[NUM_STAGES-1];
  assign IN_READY = (state_q == IDLE) && !ack_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; registered outputs are decoded from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
          data_d  = IN_DATA;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_d  = (state_d == REQ);
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE);
  end

  assign TX_DATA = data_q;
  assign TX_REQ  = req_q;
  assign DONE    = done_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: a behavioural destination responder,
// a data scoreboard, a transfer table and a per-cycle spurious-ACK table.
module tb_cdc_handshake_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned NS = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] tx_data;
  logic         tx_req;
  logic         tx_ack;
  logic         done;
  logic         busy;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  logic [W-1:0] sb[$];

  bit   auto_ack = 1'b1;
  logic man_ack  = 1'b0;
  int   rise_dly = 0;
  int   fall_dly = 0;

  typedef struct {
    logic [W-1:0] data;
    int           rise;
    int           fall;
    int           lat;
  } xfer_t;

  typedef struct {
    logic         ack;
    logic         valid;
    logic [W-1:0] data;
    logic         exp_ready;
    logic         exp_req;
    logic         exp_busy;
    logic         exp_done;
  } cyc_t;

  cdc_handshake_tx #(.BUS_WIDTH(W), .NUM_STAGES(NS)) dut (
    .CLK      (clk),
    .RST      (rst),
    .IN_DATA  (in_data),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .TX_DATA  (tx_data),
    .TX_REQ   (tx_req),
    .TX_ACK   (tx_ack),
    .DONE     (done),
    .BUSY     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Destination model: ACK rises rise_dly edges after REQ rises, falls fall_dly
  // edges after REQ falls (0/0 behaves as a zero-delay copy of REQ).
  initial begin
    int r_cnt;
    int f_cnt;
    r_cnt  = 0;
    f_cnt  = 0;
    tx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_ack) begin
        tx_ack = man_ack;
        r_cnt  = 0;
        f_cnt  = 0;
      end else if (tx_req) begin
        f_cnt = 0;
        if (!tx_ack) begin
          if (r_cnt >= rise_dly) tx_ack = 1'b1;
          r_cnt++;
        end
      end else begin
        r_cnt = 0;
        if (tx_ack) begin
          if (f_cnt >= fall_dly) tx_ack = 1'b0;
          f_cnt++;
        end
      end
    end
  end

  // DONE pulse counter, sampled away from both the active edge and the main sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [W-1:0] d, input string nm);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, 32'(in_ready), 1);
    in_data  = d;
    in_valid = 1'b1;
    sb.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_req"},     32'(tx_req),   1);
    check({nm, "_data"},    32'(tx_data),  32'(d));
    check({nm, "_busy"},    32'(busy),     1);
    check({nm, "_notrdy"},  32'(in_ready), 0);
  endtask

  // Called at the negedge 'start' cycles after the accept edge.
  task automatic wait_done(input int exp_lat, input int exp_req_hi, input int start, input string nm);
    int lat    = start;
    int req_hi = 0;
    int bad    = 0;
    logic [W-1:0] exp_d;
    if (sb.size() == 0) begin
      check({nm, "_sb_empty"}, 1, 0);
      return;
    end
    exp_d = sb[0];
    while (done !== 1'b1 && lat < 200) begin
      if (tx_data !== exp_d) bad++;
      if (busy !== 1'b1) bad++;
      if (tx_req === 1'b1) req_hi++;
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 32'(lat),    32'(exp_lat));
    check({nm, "_req_hi"},  32'(req_hi), 32'(exp_req_hi));
    check({nm, "_stable"},  32'(bad),    0);
    check({nm, "_done"},    32'(done),   1);
    check({nm, "_sbdata"},  32'(tx_data), 32'(sb.pop_front()));
    @(negedge clk);
    check({nm, "_done_1c"}, 32'(done), 0);
    check({nm, "_idle"},    32'(busy), 0);
  endtask

  initial begin
    xfer_t xt[5];
    cyc_t  ct[10];
    int    dc0;
    int    bad;
    int    lat;
    int    n;

    xt[0] = '{8'hA5, 0, 0, 6};
    xt[1] = '{8'hFF, 0, 0, 6};
    xt[2] = '{8'h00, 1, 2, 9};
    xt[3] = '{8'h5A, 3, 0, 9};
    xt[4] = '{8'hC3, 10, 7, 23};

    // ACK applied at the edge after row i is driven; synchronized two edges later.
    ct[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    ct[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    ct[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    ct[3] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0};
    ct[4] = '{1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b0};
    ct[5] = '{1'b0, 1'b1, 8'h79, 1'b0, 1'b0, 1'b0, 1'b0};
    ct[6] = '{1'b0, 1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, 1'b0};
    ct[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    ct[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    ct[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(tx_req),   0);
    check("rst_data",  32'(tx_data),  0);
    check("rst_busy",  32'(busy),     0);
    check("rst_done",  32'(done),     0);
    check("rst_ready", 32'(in_ready), 1);
    rst = 1'b1;

    // Transfer table; the first row is accepted on the first edge after reset release.
    for (int i = 0; i < 5; i++) begin
      rise_dly = xt[i].rise;
      fall_dly = xt[i].fall;
      send(xt[i].data, $sformatf("xfer%0d", i));
      wait_done(xt[i].lat, xt[i].rise + 3, 0, $sformatf("xfer%0d", i));
    end

    // Back-to-back with IN_VALID held high.
    rise_dly = 0;
    fall_dly = 0;
    dc0      = done_cnt;
    in_data  = 8'h11;
    in_valid = 1'b1;
    sb.push_back(8'h11);
    @(negedge clk);
    check("b2b_first_data", 32'(tx_data), 32'h11);
    in_data = 8'h22;
    sb.push_back(8'h22);
    bad = 0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    if (in_ready !== 1'b0) bad++;
    check("b2b_ready_low", 32'(bad), 0);
    check("b2b_lat1",      32'(lat), 6);
    check("b2b_data1",     32'(tx_data), 32'(sb.pop_front()));
    @(negedge clk);
    check("b2b_ready_again", 32'(in_ready), 1);
    check("b2b_hold_data",   32'(tx_data),  32'h11);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_req",  32'(tx_req),  1);
    check("b2b_second_data", 32'(tx_data), 32'h22);
    wait_done(6, 3, 0, "b2b2");
    check("b2b_two_dones", 32'(done_cnt - dc0), 2);

    // IN_VALID while busy is ignored.
    send(8'h5A, "busy");
    @(negedge clk);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_data_kept", 32'(tx_data), 32'h5A);
    wait_done(6, 1, 2, "busy");
    repeat (5) @(negedge clk);
    check("busy_no_req",  32'(tx_req),  0);
    check("busy_no_busy", 32'(busy),    0);
    check("busy_no_3c",   32'(tx_data), 32'h5A);

    // Spurious ACK in IDLE, per-cycle table.
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    dc0      = done_cnt;
    for (int i = 0; i < 10; i++) begin
      man_ack  = ct[i].ack;
      in_valid = ct[i].valid;
      in_data  = ct[i].data;
      @(negedge clk);
      check($sformatf("spur%0d_ready", i), 32'(in_ready), 32'(ct[i].exp_ready));
      check($sformatf("spur%0d_req", i),   32'(tx_req),   32'(ct[i].exp_req));
      check($sformatf("spur%0d_busy", i),  32'(busy),     32'(ct[i].exp_busy));
      check($sformatf("spur%0d_done", i),  32'(done),     32'(ct[i].exp_done));
    end
    in_valid = 1'b0;
    check("spur_data_kept", 32'(tx_data), 32'h5A);
    check("spur_no_done",   32'(done_cnt - dc0), 0);

    // Reset while in REL aborts without DONE.
    auto_ack = 1'b1;
    rise_dly = 0;
    fall_dly = 5;
    send(8'h96, "rrel");
    repeat (4) @(negedge clk);
    check("rrel_in_rel_busy", 32'(busy),   1);
    check("rrel_in_rel_req",  32'(tx_req), 0);
    dc0 = done_cnt;
    #1;
    rst = 1'b0;
    #1;
    check("rrel_req",   32'(tx_req),   0);
    check("rrel_data",  32'(tx_data),  0);
    check("rrel_busy",  32'(busy),     0);
    check("rrel_done",  32'(done),     0);
    check("rrel_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rrel_ack_blocks", 32'(in_ready), 0);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rrel_ready_after_ack", 32'(in_ready), 1);
    repeat (8) @(negedge clk);
    check("rrel_no_done",  32'(done_cnt - dc0), 0);
    check("rrel_idle_req", 32'(tx_req), 0);
    check("sb_drained",    32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
